video_timing_gen: RTL and testbench



---
 rtl/video_timing_pkg.sv | 30 +++
 rtl/vtg_axis_counter.sv | 56 +++++
 rtl/video_timing_gen.sv | 176 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared definitions for video_timing_gen: config field addresses, the per-axis
// timing record and a helper returning the total length of an axis.
package video_timing_pkg;

    // Timing fields are carried at this fixed width. Designs use CW <= VTG_MAX_CW.
    localparam int VTG_MAX_CW  = 16;
    localparam int VTG_TOTAL_W = VTG_MAX_CW + 2;

    localparam logic [2:0] CFG_H_ACTIVE = 3'd0;
    localparam logic [2:0] CFG_H_FP     = 3'd1;
    localparam logic [2:0] CFG_H_SYNC   = 3'd2;
    localparam logic [2:0] CFG_H_BP     = 3'd3;
    localparam logic [2:0] CFG_V_ACTIVE = 3'd4;
    localparam logic [2:0] CFG_V_FP     = 3'd5;
    localparam logic [2:0] CFG_V_SYNC   = 3'd6;
    localparam logic [2:0] CFG_V_BP     = 3'd7;

    typedef struct packed {
        logic [VTG_MAX_CW-1:0] active;
        logic [VTG_MAX_CW-1:0] fp;
        logic [VTG_MAX_CW-1:0] sync;
        logic [VTG_MAX_CW-1:0] bp;
    } axis_timing_t;

    function automatic logic [VTG_TOTAL_W-1:0] axis_total(input axis_timing_t t);
        return VTG_TOTAL_W'(t.active) + VTG_TOTAL_W'(t.fp)
             + VTG_TOTAL_W'(t.sync) + VTG_TOTAL_W'(t.bp);
    endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: a wrapping position counter plus active/sync decode of the
// position it will hold after the coming clock edge.
module vtg_axis_counter
    import video_timing_pkg::*;
#(
    parameter int            CW          = 12,
    parameter logic [CW-1:0] RESET_COUNT = '0
) (
    input  logic          pixel_clock,
    input  logic          reset,
    input  logic          advance,
    input  axis_timing_t  timing,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          active_next,
    output logic          sync_next
);

    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;
    logic [VTG_TOTAL_W-1:0] total;
    logic [VTG_TOTAL_W-1:0] last;
    logic [VTG_TOTAL_W-1:0] count_ext;
    logic [VTG_TOTAL_W-1:0] next_ext;
    logic [VTG_TOTAL_W-1:0] sync_lo;
    logic [VTG_TOTAL_W-1:0] sync_hi;

    assign total = axis_total(timing);
    assign last  = total - VTG_TOTAL_W'(1);

    // Decode uses the next count so the registered outputs line up with the count.
    always_comb begin
        count_ext = VTG_TOTAL_W'(count_q);
        wrap      = (count_ext >= last);
        count_d   = count_q;
        if (advance) begin
            count_d = wrap ? '0 : count_q + CW'(1);
        end
        next_ext    = VTG_TOTAL_W'(count_d);
        sync_lo     = VTG_TOTAL_W'(timing.active) + VTG_TOTAL_W'(timing.fp);
        sync_hi     = sync_lo + VTG_TOTAL_W'(timing.sync);
        active_next = (next_ext < VTG_TOTAL_W'(timing.active));
        sync_next   = (next_ext >= sync_lo) && (next_ext < sync_hi);
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            count_q <= RESET_COUNT;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered hsync/vsync/active, coordinates and strobes.
// Define VTG_CFG_PORT_EN to add the shadowed run-time timing port (commits at frame start).
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   CW       = 12,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic          pixel_clock,
    input  logic          reset,
    input  logic          enable,
`ifdef VTG_CFG_PORT_EN
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [CW-1:0] cfg_wdata,
`endif
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] pixel_count,
    output logic [CW-1:0] line_count,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_count
);

    localparam logic [CW-1:0] H_RESET = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_RESET = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam logic [7:0][CW-1:0] FIELD_RESET = {
        CW'(V_BP), CW'(V_SYNC), CW'(V_FP), CW'(V_ACTIVE),
        CW'(H_BP), CW'(H_SYNC), CW'(H_FP), CW'(H_ACTIVE)
    };

    logic [7:0][CW-1:0] live;
    axis_timing_t       h_timing;
    axis_timing_t       v_timing;

    logic        h_wrap, v_wrap;
    logic        h_active_n, v_active_n;
    logic        h_sync_n, v_sync_n;
    logic        v_advance;

    logic        active_q, active_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        first_frame_q, first_frame_d;

`ifdef VTG_CFG_PORT_EN
    logic [7:0][CW-1:0] shadow_q, shadow_d;
    logic [7:0][CW-1:0] live_q, live_d;

    // Commit copies the pre-write shadow, so a coincident write waits a frame.
    always_comb begin
        shadow_d = shadow_q;
        live_d   = live_q;
        if (cfg_we && (cfg_wdata != '0)) begin
            shadow_d[cfg_addr] = cfg_wdata;
        end
        if (frame_start_d) begin
            live_d = shadow_q;
        end
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            shadow_q <= FIELD_RESET;
            live_q   <= FIELD_RESET;
        end else begin
            shadow_q <= shadow_d;
            live_q   <= live_d;
        end
    end

    assign live = live_q;
`else
    assign live = FIELD_RESET;
`endif

    always_comb begin
        h_timing.active = VTG_MAX_CW'(live[CFG_H_ACTIVE]);
        h_timing.fp     = VTG_MAX_CW'(live[CFG_H_FP]);
        h_timing.sync   = VTG_MAX_CW'(live[CFG_H_SYNC]);
        h_timing.bp     = VTG_MAX_CW'(live[CFG_H_BP]);
        v_timing.active = VTG_MAX_CW'(live[CFG_V_ACTIVE]);
        v_timing.fp     = VTG_MAX_CW'(live[CFG_V_FP]);
        v_timing.sync   = VTG_MAX_CW'(live[CFG_V_SYNC]);
        v_timing.bp     = VTG_MAX_CW'(live[CFG_V_BP]);
    end

    vtg_axis_counter #(
        .CW          (CW),
        .RESET_COUNT (H_RESET)
    ) u_h_axis (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .advance     (enable),
        .timing      (h_timing),
        .count       (pixel_count),
        .wrap        (h_wrap),
        .active_next (h_active_n),
        .sync_next   (h_sync_n)
    );

    vtg_axis_counter #(
        .CW          (CW),
        .RESET_COUNT (V_RESET)
    ) u_v_axis (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .advance     (v_advance),
        .timing      (v_timing),
        .count       (line_count),
        .wrap        (v_wrap),
        .active_next (v_active_n),
        .sync_next   (v_sync_n)
    );

    // The first frame after reset is not counted as completed.
    always_comb begin
        line_start_d  = enable && h_wrap;
        frame_start_d = line_start_d && v_wrap;
        v_advance     = line_start_d;
        active_d      = h_active_n && v_active_n;
        hsync_d       = h_sync_n ? HS_POL : ~HS_POL;
        vsync_d       = v_sync_n ? VS_POL : ~VS_POL;
        frame_count_d = frame_count_q;
        first_frame_d = first_frame_q;
        if (frame_start_d) begin
            if (!first_frame_q) begin
                frame_count_d = frame_count_q + 16'd1;
            end
            first_frame_d = 1'b0;
        end
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            active_q      <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 16'd0;
            first_frame_q <= 1'b1;
        end else begin
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            first_frame_q <= first_frame_d;
        end
    end

    assign active      = active_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen using a reduced raster (25 x 11) so whole
// frames stay short; also exercises VTG_CFG_PORT_EN when that macro is defined.
`timescale 1ns/1ps
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int   CW  = 12;
    localparam int   HA  = 16, HFP = 2, HSW = 4, HBP = 3;
    localparam int   VA  = 6,  VFP = 1, VSW = 2, VBP = 2;
    localparam logic HSP = 1'b0;
    localparam logic VSP = 1'b1;
    localparam int   HT  = 25;
    localparam int   VT  = 11;
    localparam int   FT  = 275;

    logic          pixel_clock = 1'b0;
    logic          reset       = 1'b1;
    logic          enable      = 1'b0;
`ifdef VTG_CFG_PORT_EN
    logic          cfg_we      = 1'b0;
    logic [2:0]    cfg_addr    = 3'd0;
    logic [CW-1:0] cfg_wdata   = '0;
`endif
    logic          hsync, vsync, active, line_start, frame_start;
    logic [CW-1:0] pixel_count, line_count;
    logic [15:0]   frame_count;

    video_timing_gen #(
        .CW(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP)
    ) dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .enable      (enable),
`ifdef VTG_CFG_PORT_EN
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
`endif
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .pixel_count (pixel_count),
        .line_count  (line_count),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    always #5 pixel_clock = ~pixel_clock;

    typedef struct packed {
        logic [11:0] pixel;
        logic [11:0] line;
        logic        hs;
        logic        vs;
        logic        act;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    typedef struct {
        logic en;
        int   n;
        exp_t e;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[14];
    int   checks   = 0;
    int   failures = 0;
    int   mpos     = -1;
    logic track    = 1'b1;

    function automatic exp_t mk(input int px, input int ln, input logic hs, input logic vs,
                                input logic act, input logic ls, input logic fs, input int fc);
        exp_t e;
        e.pixel = 12'(px);
        e.line  = 12'(ln);
        e.hs    = hs;
        e.vs    = vs;
        e.act   = act;
        e.ls    = ls;
        e.fs    = fs;
        e.fc    = 16'(fc);
        return e;
    endfunction

    // Expected outputs from the absolute number of enabled edges since reset.
    function automatic exp_t model(input int pos, input logic adv);
        int p, l;
        if (pos < 0) return mk(HT - 1, VT - 1, ~HSP, ~VSP, 1'b0, 1'b0, 1'b0, 0);
        p = pos % HT;
        l = (pos / HT) % VT;
        return mk(p, l,
                  (p >= HA + HFP && p < HA + HFP + HSW) ? HSP : ~HSP,
                  (l >= VA + VFP && l < VA + VFP + VSW) ? VSP : ~VSP,
                  (p < HA) && (l < VA),
                  adv && (p == 0),
                  adv && (p == 0) && (l == 0),
                  (pos / FT) % 65536);
    endfunction

    function automatic exp_t sample();
        return mk(int'(pixel_count), int'(line_count), hsync, vsync, active,
                  line_start, frame_start, int'(frame_count));
    endfunction

    task automatic checkOutput(input string name, input exp_t got, input exp_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got px=%0d ln=%0d hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d, expected px=%0d ln=%0d hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d",
                     name, got.pixel, got.line, got.hs, got.vs, got.act, got.ls, got.fs, got.fc,
                     exp.pixel, exp.line, exp.hs, exp.vs, exp.act, exp.ls, exp.fs, exp.fc);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One clock: push the model's prediction, then compare after the edge.
    task automatic applyStimulus(input logic en);
        enable = en;
        if (track) begin
            if (reset) mpos = -1;
            else if (en) mpos++;
            sbq.push_back(model(mpos, en && !reset));
        end
        @(posedge pixel_clock);
        #1;
        if (track && sbq.size() > 0) checkOutput("scoreboard", sample(), sbq.pop_front());
    endtask

`ifdef VTG_CFG_PORT_EN
    task automatic cfgWrite(input logic [2:0] addr, input int data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = CW'(data);
        applyStimulus(1'b1);
        cfg_we    = 1'b0;
    endtask

    task automatic measureLine(output int len, output int hs_start, output int hs_w);
        len = -1; hs_start = -1; hs_w = 0;
        for (int k = 0; k < 200 && !line_start; k++) applyStimulus(1'b1);
        if (line_start) begin
            for (int k = 1; k <= 200; k++) begin
                if (hsync == HSP) begin
                    if (hs_start < 0) hs_start = int'(pixel_count);
                    hs_w++;
                end
                applyStimulus(1'b1);
                if (line_start) begin
                    len = k;
                    break;
                end
            end
        end
    endtask

    task automatic waitFrameStart(output int ok);
        ok = 0;
        for (int k = 0; k < 1000; k++) begin
            applyStimulus(1'b1);
            if (frame_start) begin
                ok = 1;
                break;
            end
        end
    endtask
`endif

    initial begin
        int n_act, n_hs, n_vs, interval;
`ifdef VTG_CFG_PORT_EN
        int len, hs_start, hs_w, ok, found;
`endif
        vecs[0]  = '{en: 1'b1, n: 1,   e: mk(0,  0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0)};
        vecs[1]  = '{en: 1'b1, n: 18,  e: mk(18, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0)};
        vecs[2]  = '{en: 1'b1, n: 4,   e: mk(22, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0)};
        vecs[3]  = '{en: 1'b1, n: 3,   e: mk(0,  1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0)};
        vecs[4]  = '{en: 1'b1, n: 150, e: mk(0,  7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0)};
        vecs[5]  = '{en: 1'b1, n: 50,  e: mk(0,  9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0)};
        vecs[6]  = '{en: 1'b1, n: 50,  e: mk(0,  0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1)};
        vecs[7]  = '{en: 1'b1, n: 60,  e: mk(10, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1)};
        vecs[8]  = '{en: 1'b0, n: 10,  e: mk(10, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1)};
        vecs[9]  = '{en: 1'b1, n: 1,   e: mk(11, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1)};
        vecs[10] = '{en: 1'b1, n: 114, e: mk(0,  7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1)};
        vecs[11] = '{en: 1'b0, n: 3,   e: mk(0,  7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1)};
        vecs[12] = '{en: 1'b1, n: 1,   e: mk(1,  7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1)};
        vecs[13] = '{en: 1'b1, n: 374, e: mk(0,  0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3)};

        $display("[TB] start");
        reset = 1'b1;
        repeat (3) applyStimulus(1'b1);
        checkOutput("reset_state", sample(), mk(24, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            repeat (vecs[i].n) applyStimulus(vecs[i].en);
            checkOutput($sformatf("vec%0d", i), sample(), vecs[i].e);
        end

        n_act = active ? 1 : 0;
        n_hs  = (hsync == HSP) ? 1 : 0;
        n_vs  = (vsync == VSP) ? 1 : 0;
        interval = -1;
        for (int k = 1; k <= FT + 10; k++) begin
            applyStimulus(1'b1);
            if (frame_start) begin
                interval = k;
                break;
            end
            if (active) n_act++;
            if (hsync == HSP) n_hs++;
            if (vsync == VSP) n_vs++;
        end
        checkValue("frame_period", interval, FT);
        checkValue("active_cycles", n_act, HA * VA);
        checkValue("hsync_cycles", n_hs, HSW * VT);
        checkValue("vsync_cycles", n_vs, VSW * HT);

        repeat (119) applyStimulus(1'b1);
        checkOutput("pre_reset", sample(), mk(19, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4));
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", sample(), mk(24, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        applyStimulus(1'b1);
        reset = 1'b0;
        applyStimulus(1'b1);
        checkOutput("post_reset_first", sample(), mk(0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0));

`ifdef VTG_CFG_PORT_EN
        track = 1'b0;
        repeat (30) applyStimulus(1'b1);
        cfgWrite(CFG_H_ACTIVE, 8);
        cfgWrite(CFG_H_SYNC, 0);
        measureLine(len, hs_start, hs_w);
        checkValue("cfg_old_line_len", len, 25);
        checkValue("cfg_old_hs_start", hs_start, 18);
        waitFrameStart(ok);
        checkValue("cfg_commit_fs_seen", ok, 1);
        measureLine(len, hs_start, hs_w);
        checkValue("cfg_new_line_len", len, 17);
        checkValue("cfg_new_hs_start", hs_start, 10);
        checkValue("cfg_zero_write_ignored", hs_w, 4);

        found = 0;
        for (int k = 0; k < 400; k++) begin
            if (line_count == 12'(VT - 1) && pixel_count == 12'd16) begin
                found = 1;
                break;
            end
            applyStimulus(1'b1);
        end
        checkValue("cfg_last_pixel_found", found, 1);
        cfgWrite(CFG_H_ACTIVE, 12);
        checkValue("cfg_coincident_fs", int'(frame_start), 1);
        measureLine(len, hs_start, hs_w);
        checkValue("cfg_coincident_len", len, 17);
        checkValue("cfg_coincident_hs_start", hs_start, 10);
        waitFrameStart(ok);
        checkValue("cfg_late_fs_seen", ok, 1);
        measureLine(len, hs_start, hs_w);
        checkValue("cfg_late_line_len", len, 21);
        checkValue("cfg_late_hs_start", hs_start, 14);
        checkValue("cfg_late_hs_width", hs_w, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
